mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning memory read latency in cycles (legal range 1..7).
REQ-002 SHALL have parameter DEPTH, default 1024, meaning data memory words.
REQ-003 SHALL have parameter STARVE_MAX, default 4, meaning the maximum consecutive M grants while L is pending.
REQ-004 SHALL have port clk  in  1  single clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port m_req/m_we  in  1/1  pipeline memory-stage request and write enable.
REQ-007 SHALL have port m_addr/m_wdata  in  64/64  pipeline word address and write data.
REQ-008 SHALL have port m_done/m_err  out  1/1  pipeline completion pulse and address-error flag.
REQ-009 SHALL have port m_rdata  out  64  pipeline read data.
REQ-010 SHALL have ports l_req, l_we, l_addr, l_wdata, l_done, l_err, l_rdata with the same directions and widths as the m_ ports; they serve the loader/debug requester.
REQ-011 SHALL have port mem_en/mem_we  out  1/1  memory access strobe and write enable.
REQ-012 SHALL have port mem_addr  out  10  memory word address, equal to addr[9:0].
REQ-013 SHALL have port mem_wdata  out  64  memory write data.
REQ-014 SHALL have port mem_rdata  in  64  memory read data, valid MEM_LAT cycles after the mem_en cycle.

Function
REQ-015 Requester handshake SHALL be: requester holds req, we, addr and wdata stable until its done pulse; done is high for exactly 1 cycle per transaction.
REQ-016 FSM states SHALL be IDLE, ACCESS and DONE; exactly one transaction SHALL be in flight at a time.
REQ-017 In IDLE, if any req is high, the FSM SHALL latch the winner's id, we, addr and wdata, then go to ACCESS on the next edge.
REQ-018 Arbitration SHALL be fixed priority M over L, except that L wins when l_req=1 and starve_cnt==STARVE_MAX.
REQ-019 starve_cnt (3 bits) SHALL increment on each M grant while l_req=1, clear on any L grant or when l_req=0, and saturate at STARVE_MAX.
REQ-020 On the first ACCESS cycle the block SHALL drive mem_en=1, mem_we=latched we, mem_addr and mem_wdata from the latched values; mem_en SHALL be 0 in all other cycles.
REQ-021 A latency counter SHALL hold ACCESS for exactly MEM_LAT cycles, then move to DONE.
REQ-022 For a read, rdata SHALL capture mem_rdata on the last ACCESS cycle; for a write, rdata SHALL be 0.
REQ-023 In DONE the block SHALL pulse the winner's done and present its rdata/err, then return to IDLE; rdata/err SHALL hold until the next done for that requester.
REQ-024 Request-to-done latency SHALL be MEM_LAT+2 cycles, and back-to-back throughput SHALL be one transaction per MEM_LAT+2 cycles.
REQ-025 Out-of-range accesses (addr >= DEPTH) SHALL NOT assert mem_en; ACCESS timing SHALL be unchanged, and done is accompanied by err=1 and rdata=0.
REQ-026 If req deasserts mid-transaction, the transaction SHALL still complete and done SHALL still pulse.
REQ-027 Simultaneous m_req and l_req in IDLE SHALL be resolved by REQ-018; the loser is not acknowledged and keeps waiting.
REQ-028 The non-winning requester's done SHALL stay 0; the two done outputs SHALL never both be 1.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 Asserting reset SHALL immediately force: state IDLE; mem_en, mem_we, m_done, l_done, m_err and l_err to 0; mem_addr, mem_wdata, m_rdata and l_rdata to 0; starve_cnt to 0.
REQ-031 Reset during ACCESS SHALL abort the transaction with no done pulse; a write already strobed into memory is not undone.
REQ-032 After reset deassertion, the first arbitration SHALL occur on the first rising edge with req high.

Verification
REQ-033 M read test (MEM_LAT=1): m_req=1, m_addr=5, memory word 5=64'd2 -> mem_en high for 1 cycle at cycle 1, m_done at cycle 3, m_rdata=2, m_err=0.
REQ-034 L write test: l_req=1, l_we=1, l_addr=7, l_wdata=64'hAB -> mem_we=1 with mem_addr=7 and mem_wdata=AB; l_done pulses once; l_rdata=0.
REQ-035 Contention test: m_req and l_req held high continuously -> grant order M,M,M,M,L,M,M,M,M,L; no double done.
REQ-036 Range test: m_addr=1024 read -> no mem_en, m_done at cycle 3 with m_err=1 and m_rdata=0.
REQ-037 Reset test: reset asserted in ACCESS cycle of a read -> all outputs 0 immediately, no done; a new m_req after release completes normally.
REQ-038 Latency test: MEM_LAT=3 -> done at cycle 5; L request dropped mid-flight still gets l_done.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester arbiter for a single-ported data memory.
//               Requester M (pipeline memory stage) has fixed priority over
//               requester L (loader/debug). L is guaranteed service after
//               STARVE_MAX consecutive M grants while L is waiting. One
//               transaction is in flight at a time: IDLE -> ACCESS (MEM_LAT
//               cycles) -> DONE -> IDLE, i.e. MEM_LAT+2 cycles per access.
// Ports       : clk, reset           - clock, async active-high reset
//               m_req/m_we/m_addr/m_wdata -> m_done/m_err/m_rdata (M side)
//               l_req/l_we/l_addr/l_wdata -> l_done/l_err/l_rdata (L side)
//               mem_en/mem_we/mem_addr/mem_wdata -> memory, mem_rdata <- memory
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int DEPTH      = 1024,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    // pipeline (M) requester
    input  logic        m_req,
    input  logic        m_we,
    input  logic [63:0] m_addr,
    input  logic [63:0] m_wdata,
    output logic        m_done,
    output logic        m_err,
    output logic [63:0] m_rdata,
    // loader/debug (L) requester
    input  logic        l_req,
    input  logic        l_we,
    input  logic [63:0] l_addr,
    input  logic [63:0] l_wdata,
    output logic        l_done,
    output logic        l_err,
    output logic [63:0] l_rdata,
    // memory side
    output logic        mem_en,
    output logic        mem_we,
    output logic [9:0]  mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    localparam logic [2:0]  c_starve_max = 3'(STARVE_MAX);
    localparam logic [2:0]  c_lat_last   = 3'(MEM_LAT - 1);
    localparam logic [63:0] c_depth      = 64'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_id;          // 0 = M owns the transaction, 1 = L
    logic        r_we;
    logic        r_oor;         // latched address was out of range
    logic [2:0]  r_lat_cnt;
    logic [2:0]  r_starve_cnt;

    logic        w_any_req;
    logic        w_grant_l;
    logic        w_sel_we;
    logic        w_sel_oor;
    logic [63:0] w_sel_addr;
    logic [63:0] w_sel_wdata;
    logic [63:0] w_done_rdata;

    always_comb begin
        w_any_req    = m_req | l_req;
        // M wins unless L has been passed over STARVE_MAX times in a row
        w_grant_l    = l_req & (~m_req | (r_starve_cnt == c_starve_max));
        w_sel_we     = w_grant_l ? l_we    : m_we;
        w_sel_addr   = w_grant_l ? l_addr  : m_addr;
        w_sel_wdata  = w_grant_l ? l_wdata : m_wdata;
        w_sel_oor    = (w_sel_addr >= c_depth);
        // Writes and rejected accesses return zero instead of bus data
        w_done_rdata = (r_we | r_oor) ? 64'd0 : mem_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_id         <= 1'b0;
            r_we         <= 1'b0;
            r_oor        <= 1'b0;
            r_lat_cnt    <= 3'd0;
            r_starve_cnt <= 3'd0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 10'd0;
            mem_wdata    <= 64'd0;
            m_done       <= 1'b0;
            m_err        <= 1'b0;
            m_rdata      <= 64'd0;
            l_done       <= 1'b0;
            l_err        <= 1'b0;
            l_rdata      <= 64'd0;
        end else begin
            // Strobes and done pulses last exactly one cycle
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            m_done <= 1'b0;
            l_done <= 1'b0;

            // Starvation tracking only counts while L is actually waiting
            if (!l_req) begin
                r_starve_cnt <= 3'd0;
            end else if (r_state == ST_IDLE && w_any_req) begin
                if (w_grant_l) begin
                    r_starve_cnt <= 3'd0;
                end else if (r_starve_cnt < c_starve_max) begin
                    r_starve_cnt <= r_starve_cnt + 3'd1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_id      <= w_grant_l;
                        r_we      <= w_sel_we;
                        r_oor     <= w_sel_oor;
                        r_lat_cnt <= 3'd0;
                        // Memory strobe is issued with the state change so it
                        // is visible on the first ACCESS cycle; rejected
                        // addresses never reach the memory.
                        mem_addr  <= w_sel_addr[9:0];
                        mem_wdata <= w_sel_wdata;
                        mem_en    <= ~w_sel_oor;
                        mem_we    <= w_sel_we & ~w_sel_oor;
                        r_state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_lat_cnt == c_lat_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 3'd1;
                    end
                end
                ST_DONE: begin
                    // mem_rdata is valid exactly MEM_LAT cycles after the
                    // strobe cycle, which is this cycle.
                    if (r_id) begin
                        l_done  <= 1'b1;
                        l_err   <= r_oor;
                        l_rdata <= w_done_rdata;
                    end else begin
                        m_done  <= 1'b1;
                        m_err   <= r_oor;
                        m_rdata <= w_done_rdata;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Two instances are built,
//               one with MEM_LAT=1 and one with MEM_LAT=3, each attached to a
//               behavioural memory whose read data is only valid in the cycle
//               MEM_LAT after the strobe. Expected values come from a
//               transaction-level reference memory and the arbitration rule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int STARVE = 4;
    localparam int NGRANT = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // [instance][requester]: requester 0 = M, 1 = L
    logic        req   [2][2];
    logic        we    [2][2];
    logic [63:0] addr  [2][2];
    logic [63:0] wdata [2][2];
    logic        done  [2][2];
    logic        err   [2][2];
    logic [63:0] rdata [2][2];

    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [9:0]  mem_addr  [2];
    logic [63:0] mem_wdata [2];
    logic [63:0] mem_rdata [2];

    logic [63:0] ref_mem  [2][1024];
    logic [63:0] last_rd  [2][2];
    logic        last_err [2][2];

    int checks = 0;
    int errors = 0;

    function automatic logic [63:0] init_word(input int k, input int a);
        if (a == 5) return 64'd2;
        return (64'(a) * 64'h9E37_79B9_7F4A_7C15) ^ {32'(k), 32'hC0DE_0000};
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam int LAT = (k == 0) ? 1 : 3;
        logic [63:0] mem  [1024];
        logic [63:0] pipe [8];

        mem_arbiter #(
            .MEM_LAT    (LAT),
            .DEPTH      (1024),
            .STARVE_MAX (STARVE)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .m_req     (req[k][0]),
            .m_we      (we[k][0]),
            .m_addr    (addr[k][0]),
            .m_wdata   (wdata[k][0]),
            .m_done    (done[k][0]),
            .m_err     (err[k][0]),
            .m_rdata   (rdata[k][0]),
            .l_req     (req[k][1]),
            .l_we      (we[k][1]),
            .l_addr    (addr[k][1]),
            .l_wdata   (wdata[k][1]),
            .l_done    (done[k][1]),
            .l_err     (err[k][1]),
            .l_rdata   (rdata[k][1]),
            .mem_en    (mem_en[k]),
            .mem_we    (mem_we[k]),
            .mem_addr  (mem_addr[k]),
            .mem_wdata (mem_wdata[k]),
            .mem_rdata (mem_rdata[k])
        );

        assign mem_rdata[k] = pipe[LAT-1];

        // Memory: data appears LAT cycles after the strobe cycle; every other
        // stage carries random junk so a mistimed capture is visible.
        initial begin
            for (int a = 0; a < 1024; a++) mem[a] <= init_word(k, a);
            for (int i = 0; i < 8; i++) pipe[i] <= 64'd0;
            forever begin
                @(posedge clk);
                if (mem_en[k] && mem_we[k]) mem[mem_addr[k]] <= mem_wdata[k];
                pipe[0] <= (mem_en[k] && !mem_we[k]) ? mem[mem_addr[k]] : {$urandom, $urandom};
                for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input int k);
        chk("rst_mem_en", mem_en[k], 1'b0);
        chk("rst_mem_we", mem_we[k], 1'b0);
        chk("rst_mem_addr", mem_addr[k], 64'd0);
        chk("rst_mem_wdata", mem_wdata[k], 64'd0);
        for (int r = 0; r < 2; r++) begin
            chk("rst_done", done[k][r], 1'b0);
            chk("rst_err", err[k][r], 1'b0);
            chk("rst_rdata", rdata[k][r], 64'd0);
        end
    endtask

    // One transaction from a single requester, checked cycle by cycle.
    task automatic do_txn(input int k, input int r, input logic w,
                          input logic [63:0] a, input logic [63:0] wd, input bit drop_mid);
        int          lat;
        int          o;
        int          got;
        bit          oor;
        logic [63:0] exp_rd;
        lat    = (k == 0) ? 1 : 3;
        o      = 1 - r;
        got    = 0;
        oor    = (a >= 64'd1024);
        exp_rd = (w || oor) ? 64'd0 : ref_mem[k][a[9:0]];
        req[k][r]   = 1'b1;
        we[k][r]    = w;
        addr[k][r]  = a;
        wdata[k][r] = wd;
        for (int n = 1; n <= lat + 6; n++) begin
            tick();
            if (drop_mid && n == 1) req[k][r] = 1'b0;
            chk("mem_en", mem_en[k], (n == 1 && !oor));
            if (n == 1 && !oor) begin
                chk("mem_we", mem_we[k], w);
                chk("mem_addr", mem_addr[k], 64'(a[9:0]));
                chk("mem_wdata", mem_wdata[k], wd);
            end
            chk("other_done", done[k][o], 1'b0);
            if (done[k][r]) begin
                got = n;
                break;
            end
        end
        chk("latency", got, lat + 2);
        req[k][r] = 1'b0;
        chk("rdata", rdata[k][r], exp_rd);
        chk("err", err[k][r], oor);
        chk("hold_rdata", rdata[k][o], last_rd[k][o]);
        chk("hold_err", err[k][o], last_err[k][o]);
        last_rd[k][r]  = exp_rd;
        last_err[k][r] = oor;
        if (w && !oor) ref_mem[k][a[9:0]] = wd;
        tick();
        chk("done_pulse", done[k][r], 1'b0);
    endtask

    // Both requesters held high: expect M x STARVE then L, repeating.
    task automatic contention(input int k);
        int          lat;
        int          streak;
        int          grants;
        int          since;
        int          win;
        bit          exp_l;
        logic [63:0] ma;
        logic [63:0] la;
        lat    = (k == 0) ? 1 : 3;
        streak = 0;
        grants = 0;
        since  = 0;
        ma = 64'($urandom_range(0, 1023));
        la = 64'($urandom_range(0, 1023));
        for (int r = 0; r < 2; r++) begin
            req[k][r] = 1'b1;
            we[k][r]  = 1'b0;
        end
        addr[k][0] = ma;
        addr[k][1] = la;
        for (int c = 0; c < NGRANT * (lat + 2) + 10 && grants < NGRANT; c++) begin
            tick();
            since++;
            chk("double_done", done[k][0] & done[k][1], 1'b0);
            if (done[k][0] || done[k][1]) begin
                exp_l = (streak == STARVE);
                win   = done[k][1] ? 1 : 0;
                chk("grant_order", win, exp_l);
                chk("spacing", since, lat + 2);
                chk("c_rdata", rdata[k][win], ref_mem[k][win ? la[9:0] : ma[9:0]]);
                last_rd[k][win]  = ref_mem[k][win ? la[9:0] : ma[9:0]];
                last_err[k][win] = 1'b0;
                streak = exp_l ? 0 : streak + 1;
                grants++;
                since = 0;
            end
        end
        chk("grants", grants, NGRANT);
        req[k][0] = 1'b0;
        req[k][1] = 1'b0;
        tick();
    endtask

    // Reset in the ACCESS cycle of a read aborts it without a done.
    task automatic reset_test();
        req[0][0]  = 1'b1;
        we[0][0]   = 1'b0;
        addr[0][0] = 64'd9;
        tick();
        chk("pre_rst_mem_en", mem_en[0], 1'b1);
        reset = 1'b1;
        #1;
        check_zero(0);
        check_zero(1);
        req[0][0] = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 2; r++) begin
                last_rd[k][r]  = 64'd0;
                last_err[k][r] = 1'b0;
            end
        end
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("abort_no_done", done[0][0] | done[0][1], 1'b0);
        end
        do_txn(0, 0, 1'b0, 64'd9, 64'd0, 1'b0);
    endtask

    initial begin
        int          k;
        int          r;
        int          sel;
        logic [63:0] a;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                req[i][j]      = 1'b0;
                we[i][j]       = 1'b0;
                addr[i][j]     = 64'd0;
                wdata[i][j]    = 64'd0;
                last_rd[i][j]  = 64'd0;
                last_err[i][j] = 1'b0;
            end
            for (int x = 0; x < 1024; x++) ref_mem[i][x] = init_word(i, x);
        end
        tick();
        check_zero(0);
        check_zero(1);
        tick();
        reset = 1'b0;

        // MEM_LAT = 1 instance
        do_txn(0, 0, 1'b0, 64'd5, 64'd0, 1'b0);              // M read word 5 = 2
        do_txn(0, 1, 1'b1, 64'd7, 64'hAB, 1'b0);            // L write
        do_txn(0, 0, 1'b0, 64'd7, 64'd0, 1'b0);              // read back
        do_txn(0, 0, 1'b0, 64'd1024, 64'd0, 1'b0);           // first illegal address
        do_txn(0, 1, 1'b1, 64'hFFFF_FFFF_0000_0003, 64'd1, 1'b0);
        do_txn(0, 0, 1'b0, 64'd3, 64'd0, 1'b0);              // untouched by rejected write
        do_txn(0, 0, 1'b0, 64'd1023, 64'd0, 1'b0);           // last legal address
        contention(0);
        reset_test();

        // MEM_LAT = 3 instance
        do_txn(1, 0, 1'b0, 64'd5, 64'd0, 1'b0);
        do_txn(1, 1, 1'b0, 64'd5, 64'd0, 1'b1);              // L dropped mid-flight
        do_txn(1, 1, 1'b1, 64'd12, 64'h1234_5678_9ABC_DEF0, 1'b1);
        do_txn(1, 0, 1'b0, 64'd12, 64'd0, 1'b0);
        contention(1);

        // Random single-requester traffic on both instances
        for (int i = 0; i < 60; i++) begin
            k   = i % 2;
            r   = $urandom_range(0, 1);
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = 64'd1024 + 64'($urandom_range(0, 5000));
            else if (sel == 1) a = {$urandom, $urandom};
            else               a = 64'($urandom_range(0, 15));
            do_txn(k, r, 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                   ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
